// File: rtl/trace_shadow_pipe_if.sv
// Retire-record stream from trace_shadow_pipe to its consumer (checker or DPI bridge).
// Handshake: a record transfers on a clock edge where rec_valid && rec_ready; fields hold while rec_valid && !rec_ready.
interface trace_shadow_pipe_if #(
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5
);
  logic                 rec_valid;
  logic                 rec_ready;
  logic [PC_W-1:0]      rec_pc;
  logic [INSTR_W-1:0]   rec_instr;
  logic [REG_IDX_W-1:0] rec_rd;
  logic [REG_IDX_W-1:0] rec_rs;
  logic [REG_IDX_W-1:0] rec_rt;
  logic [2:0]           rec_type;
  logic                 rec_wr;
  logic [DATA_W-1:0]    rec_wdata;

  modport master (
    output rec_valid, rec_pc, rec_instr, rec_rd, rec_rs, rec_rt, rec_type, rec_wr, rec_wdata,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_pc, rec_instr, rec_rd, rec_rs, rec_rt, rec_type, rec_wr, rec_wdata,
    output rec_ready
  );
endinterface

// File: rtl/trace_shadow_pipe.sv
// Stall/flush-aware shadow pipeline of per-instruction trace records with a retire FIFO.
// Optional macro TRACE_END_DETECT_EN adds end_reg_val_i / sim_end syscall end detection.
module trace_shadow_pipe #(
  parameter int STAGES      = 4,
  parameter int HOLD_STAGES = 2,
  parameter int PC_W        = 32,
  parameter int INSTR_W     = 32,
  parameter int DATA_W      = 32,
  parameter int REG_IDX_W   = 5,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fetch_valid,
  input  logic [PC_W-1:0]      fetch_pc,
  input  logic [INSTR_W-1:0]   fetch_instr,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic [REG_IDX_W-1:0] iss_rs,
  input  logic [REG_IDX_W-1:0] iss_rt,
  input  logic [2:0]           iss_type,
  input  logic                 stall_i,
  input  logic [STAGES-1:0]    flush_i,
  input  logic                 retire_i,
  input  logic                 reg_wr_i,
  input  logic [DATA_W-1:0]    wr_data_i,
`ifdef TRACE_END_DETECT_EN
  input  logic [DATA_W-1:0]    end_reg_val_i,
  output logic                 sim_end,
`endif
  trace_shadow_pipe_if.master  rec,
  output logic [31:0]          retire_count,
  output logic                 overflow,
  output logic                 err_orphan
);

  localparam int WB    = STAGES - 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = PC_W + INSTR_W + 3*REG_IDX_W + 3 + 1 + DATA_W;

  logic [STAGES-1:0]    r_v;
  logic [PC_W-1:0]      r_pc    [STAGES];
  logic [INSTR_W-1:0]   r_instr [STAGES];
  logic [REG_IDX_W-1:0] r_rd    [1:WB];
  logic [REG_IDX_W-1:0] r_rs    [1:WB];
  logic [REG_IDX_W-1:0] r_rt    [1:WB];
  logic [2:0]           r_type  [1:WB];

  logic [STAGES-1:0]    w_in_v;
  logic [PC_W-1:0]      w_in_pc    [STAGES];
  logic [INSTR_W-1:0]   w_in_instr [STAGES];
  logic [REG_IDX_W-1:0] w_in_rd    [1:WB];
  logic [REG_IDX_W-1:0] w_in_rs    [1:WB];
  logic [REG_IDX_W-1:0] w_in_rt    [1:WB];
  logic [2:0]           w_in_type  [1:WB];

  // Stage k input is stage k-1; decode fields enter on the stage 0 -> 1 transfer.
  always_comb begin
    w_in_v        = {r_v[STAGES-2:0], fetch_valid};
    w_in_pc[0]    = fetch_pc;
    w_in_instr[0] = fetch_instr;
    for (int k = 1; k < STAGES; k++) begin
      w_in_pc[k]    = r_pc[k-1];
      w_in_instr[k] = r_instr[k-1];
    end
    w_in_rd[1]   = iss_rd;
    w_in_rs[1]   = iss_rs;
    w_in_rt[1]   = iss_rt;
    w_in_type[1] = iss_type;
    for (int k = 2; k < STAGES; k++) begin
      w_in_rd[k]   = r_rd[k-1];
      w_in_rs[k]   = r_rs[k-1];
      w_in_rt[k]   = r_rt[k-1];
      w_in_type[k] = r_type[k-1];
    end
  end

  // Held stages keep their entry, the first unheld stage takes a bubble; flush always clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stall_i && (k < HOLD_STAGES))       r_v[k] <= r_v[k] & ~flush_i[k];
        else if (stall_i && (k == HOLD_STAGES)) r_v[k] <= 1'b0;
        else                                    r_v[k] <= w_in_v[k] & ~flush_i[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (!(stall_i && (k < HOLD_STAGES))) begin
        r_pc[k]    <= w_in_pc[k];
        r_instr[k] <= w_in_instr[k];
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (!(stall_i && (k < HOLD_STAGES))) begin
        r_rd[k]   <= w_in_rd[k];
        r_rs[k]   <= w_in_rs[k];
        r_rt[k]   <= w_in_rt[k];
        r_type[k] <= w_in_type[k];
      end
    end
  end

  logic             w_wb_v;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic [REC_W-1:0] w_rec;

  logic [REC_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic [31:0]      r_retire_count;
  logic             r_overflow;
  logic             r_err_orphan;

  assign w_wb_v = r_v[WB];
  assign w_push = w_wb_v & retire_i;
  assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_cnt != '0) & rec.rec_ready;
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_rec  = {r_pc[WB], r_instr[WB], r_rd[WB], r_rs[WB], r_rt[WB], r_type[WB],
                   reg_wr_i, (reg_wr_i ? wr_data_i : {DATA_W{1'b0}})};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_cnt          <= '0;
      r_retire_count <= '0;
      r_overflow     <= 1'b0;
      r_err_orphan   <= 1'b0;
    end else begin
      if (w_push)                      r_retire_count <= r_retire_count + 32'd1;
      if (retire_i && !w_wb_v)         r_err_orphan   <= 1'b1;
      if (w_push && w_full && !w_pop)  r_overflow     <= 1'b1;
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_rec;
  end

  assign rec.rec_valid = (r_cnt != '0);
  assign {rec.rec_pc, rec.rec_instr, rec.rec_rd, rec.rec_rs, rec.rec_rt,
          rec.rec_type, rec.rec_wr, rec.rec_wdata} = r_mem[r_rptr];

  assign retire_count = r_retire_count;
  assign overflow     = r_overflow;
  assign err_orphan   = r_err_orphan;

`ifdef TRACE_END_DETECT_EN
  logic r_sim_end;

  // Simulation ends on a retired syscall with register 2 holding 0xA.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sim_end <= 1'b0;
    end else if (w_push && (r_instr[WB] == INSTR_W'(32'h0000000C)) &&
                 (end_reg_val_i == DATA_W'(32'h0000000A))) begin
      r_sim_end <= 1'b1;
    end
  end

  assign sim_end = r_sim_end;
`endif

endmodule

// File: tb/tb_trace_shadow_pipe.sv
// Randomized scoreboard bench for trace_shadow_pipe against a stage-rule reference model.
module tb_trace_shadow_pipe;
  localparam int STAGES = 4;
  localparam int HOLD   = 2;
  localparam int DEPTH  = 8;
  localparam int REC_W  = 32 + 32 + 15 + 3 + 1 + 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_instr = '0;
  logic [4:0]  iss_rd = '0, iss_rs = '0, iss_rt = '0;
  logic [2:0]  iss_type = '0;
  logic        stall_i = 1'b0;
  logic [3:0]  flush_i = '0;
  logic        retire_i = 1'b0;
  logic        reg_wr_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic [31:0] retire_count;
  logic        overflow;
  logic        err_orphan;
`ifdef TRACE_END_DETECT_EN
  logic [31:0] end_reg_val_i = '0;
  logic        sim_end;
`endif

  trace_shadow_pipe_if #(.PC_W(32), .INSTR_W(32), .DATA_W(32), .REG_IDX_W(5)) rec_if ();

  trace_shadow_pipe #(
    .STAGES(STAGES), .HOLD_STAGES(HOLD), .PC_W(32), .INSTR_W(32),
    .DATA_W(32), .REG_IDX_W(5), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .iss_rd(iss_rd), .iss_rs(iss_rs), .iss_rt(iss_rt), .iss_type(iss_type),
    .stall_i(stall_i), .flush_i(flush_i), .retire_i(retire_i),
    .reg_wr_i(reg_wr_i), .wr_data_i(wr_data_i),
`ifdef TRACE_END_DETECT_EN
    .end_reg_val_i(end_reg_val_i), .sim_end(sim_end),
`endif
    .rec(rec_if),
    .retire_count(retire_count), .overflow(overflow), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd, rs, rt;
    logic [2:0]  typ;
  } ent_t;

  ent_t             pipe [STAGES];
  logic [REC_W-1:0] exp_q [$];
  int               m_cnt, m_vis;
  logic [31:0]      m_rc, m_rc_vis;
  bit               m_ovf, m_ovf_vis, m_orph, m_orph_vis;
  bit               mon_en = 1'b0;
  int               n_cmp = 0;
  int               n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit wb_valid();
    return pipe[STAGES-1].v;
  endfunction

  // One clock of stimulus; the model computes what the next edge must do.
  task automatic cycle(input bit fv, input logic [31:0] pc, input logic [31:0] instr,
                       input bit st, input logic [3:0] fl, input bit ret, input bit rdy);
    ent_t             nxt [STAGES];
    ent_t             wb;
    bit               pop;
    logic [REC_W-1:0] r;
    @(posedge clk); #2;
    fetch_valid = fv; fetch_pc = pc; fetch_instr = instr;
    iss_rd = 5'($urandom); iss_rs = 5'($urandom); iss_rt = 5'($urandom);
    iss_type = 3'b001 << $urandom_range(0, 2);
    stall_i = st; flush_i = fl; retire_i = ret; rec_if.rec_ready = rdy;
    reg_wr_i = 1'($urandom); wr_data_i = $urandom;

    m_vis = m_cnt; m_rc_vis = m_rc; m_ovf_vis = m_ovf; m_orph_vis = m_orph;
    pop = (m_cnt > 0) && rdy;
    wb  = pipe[STAGES-1];
    if (ret && wb.v) begin
      m_rc++;
      r = {wb.pc, wb.instr, wb.rd, wb.rs, wb.rt, wb.typ, reg_wr_i, (reg_wr_i ? wr_data_i : 32'h0)};
      if (m_cnt < DEPTH || pop) begin
        exp_q.push_back(r);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (ret) begin
      m_orph = 1'b1;
    end
    if (pop) m_cnt--;

    for (int k = 0; k < STAGES; k++) begin
      if (st && k < HOLD) begin
        nxt[k] = pipe[k];
      end else if (st && k == HOLD) begin
        nxt[k] = pipe[k];
        nxt[k].v = 1'b0;
      end else if (k == 0) begin
        nxt[k] = '{fv, pc, instr, 5'd0, 5'd0, 5'd0, 3'd0};
      end else if (k == 1) begin
        nxt[k] = pipe[0];
        nxt[k].rd = iss_rd; nxt[k].rs = iss_rs; nxt[k].rt = iss_rt; nxt[k].typ = iss_type;
      end else begin
        nxt[k] = pipe[k-1];
      end
      if (fl[k]) nxt[k].v = 1'b0;
    end
    pipe = nxt;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'b0, wb_valid(), rdy);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1; rec_if.rec_ready = 1'b0; fetch_valid = 1'b0;
    retire_i = 1'b0; stall_i = 1'b0; flush_i = '0;
    @(posedge clk); #2;
    reset = 1'b0;
    for (int k = 0; k < STAGES; k++) pipe[k].v = 1'b0;
    exp_q.delete();
    m_cnt = 0; m_vis = 0; m_rc = '0; m_rc_vis = '0;
    m_ovf = 0; m_ovf_vis = 0; m_orph = 0; m_orph_vis = 0;
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each accepted record.
  always @(negedge clk) begin
    logic [REC_W-1:0] act, exp;
    if (mon_en && !reset) begin
      check("rec_valid", rec_if.rec_valid, (m_vis > 0));
      check("retire_count", retire_count, m_rc_vis);
      check("overflow", overflow, m_ovf_vis);
      check("err_orphan", err_orphan, m_orph_vis);
      if (rec_if.rec_valid && rec_if.rec_ready) begin
        act = {rec_if.rec_pc, rec_if.rec_instr, rec_if.rec_rd, rec_if.rec_rs, rec_if.rec_rt,
               rec_if.rec_type, rec_if.rec_wr, rec_if.rec_wdata};
        if (exp_q.size() == 0) begin
          check("unexpected_record", act, '0);
        end else begin
          exp = exp_q.pop_front();
          check("record", act, exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    rec_if.rec_ready = 1'b0;
    do_reset();
    @(negedge clk);
    check("reset_rec_valid", rec_if.rec_valid, 0);
    check("reset_retire_count", retire_count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_err_orphan", err_orphan, 0);
    mon_en = 1'b1;

    // Six sequential instructions, retired whenever WB holds one.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(i*4), $urandom, 1'b0, 4'b0, wb_valid(), 1'b1);
    idle(8, 1'b1);
    @(negedge clk);
    check("seq_retire_count", retire_count, 6);
    check("seq_queue_empty", exp_q.size(), 0);

    // Two-cycle stall mid-stream.
    pc = 32'h100;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, pc, $urandom, (i == 3 || i == 4), 4'b0, wb_valid(), 1'b1);
      if (!(i == 3 || i == 4)) pc += 4;
    end
    idle(8, 1'b1);

    // Taken-branch flush of the two youngest stages.
    pc = 32'h200;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, pc, $urandom, 1'b0, (i == 5) ? 4'b0011 : 4'b0, wb_valid(), 1'b1);
      pc += 4;
    end
    idle(8, 1'b1);
    @(negedge clk);
    check("flush_err_orphan", err_orphan, 0);
    check("flush_queue_empty", exp_q.size(), 0);

    // Overflow: nine retires into an eight-entry FIFO with the consumer stalled.
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h300 + 32'(i*4), $urandom, 1'b0, 4'b0, wb_valid(), 1'b0);
    idle(6, 1'b0);
    @(negedge clk);
    check("ovf_overflow", overflow, 1);
    check("ovf_retire_count", retire_count, 9);
    check("ovf_rec_valid", rec_if.rec_valid, 1);
    idle(12, 1'b1);
    @(negedge clk);
    check("ovf_drained", exp_q.size(), 0);

    // Orphan retire with an empty WB slot, then reset clears the flag.
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 4'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    @(negedge clk);
    check("orphan_set", err_orphan, 1);
    check("orphan_no_push", rec_if.rec_valid, 0);
    do_reset();
    @(negedge clk);
    check("orphan_cleared", err_orphan, 0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      bit ret;
      ret = wb_valid() ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 59) == 0);
      cycle(($urandom_range(0, 3) != 0), $urandom, $urandom, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0, ret, ($urandom_range(0, 3) != 0));
    end
    idle(30, 1'b1);
    @(negedge clk);
    check("random_drained", exp_q.size(), 0);

`ifdef TRACE_END_DETECT_EN
    do_reset();
    end_reg_val_i = 32'h9;
    cycle(1'b1, 32'h400, 32'h0000000C, 1'b0, 4'b0, wb_valid(), 1'b1);
    idle(6, 1'b1);
    @(negedge clk);
    check("sim_end_low", sim_end, 0);
    end_reg_val_i = 32'hA;
    cycle(1'b1, 32'h404, 32'h0000000C, 1'b0, 4'b0, wb_valid(), 1'b1);
    idle(6, 1'b1);
    @(negedge clk);
    check("sim_end_high", sim_end, 1);
`endif

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
